serial_adder: RTL

- Parametrised bit-serial adder. Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Uses one internal half-adder pair (a full-adder slice) and a carry flip-flop, so area stays constant as WIDTH grows.
- Start/busy/done handshake; the result is held stable between operations.
- Successor to the combinational half-adder cell, for datapaths where area matters more than latency.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 98 +++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master issues requests and the slave (the adder) returns results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first.
// Takes WIDTH cycles per add; result registers hold the last completed sum.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             carry_prev;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  logic p, g, s, c;

  // Two half adders composed into the single full-adder slice.
  assign p = sa[0] ^ sb[0];
  assign g = sa[0] & sb[0];
  assign s = p ^ carry;
  assign c = g | (p & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      carry_prev <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {s, acc[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c;
          cnt   <= cnt + CNT_W'(1);
          // Last slice: publish the finished word so it is valid alongside done.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            carry_prev <= carry;
            sum        <= {s, acc[WIDTH-1:1]};
            cout       <= c;
            overflow   <= c ^ carry;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.sum      = sum;
  assign bus.cout     = cout;
  assign bus.overflow = overflow;

endmodule
